// File: rtl/lvdc_mem_pkg.sv
// lvdc_mem_pkg: shared widths and enums for the main-memory arbiter
package lvdc_mem_pkg;
    localparam int ADDR_W = 15;
    localparam int WORD_W = 26;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {PORT_CPU, PORT_DMA} port_e;
endpackage

// File: rtl/lvdc_mem_arbiter_if.sv
// lvdc_mem_arbiter_if: CPU, DMA and memory-side signals of the arbiter
interface lvdc_mem_arbiter_if;
    import lvdc_mem_pkg::*;
    logic              cpu_req, cpu_we, cpu_lock, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [WORD_W-1:0] dma_wdata, dma_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    logic              mem_cs, mem_oe, mem_we, busy;
    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_cs, mem_oe, mem_we, busy
    );
    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_cs, mem_oe, mem_we, busy
    );
endinterface

// File: rtl/lvdc_mem_arb_pick.sv
// lvdc_mem_arb_pick: combinational priority decision between CPU and DMA
module lvdc_mem_arb_pick
    import lvdc_mem_pkg::*;
(
    input  logic  cpu_req,
    input  logic  dma_req,
    input  logic  lock,
    input  logic  starve,
    output logic  grant_valid,
    output port_e grant_port
);
    // lock beats starvation, starvation beats plain CPU priority
    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_port  = (lock && cpu_req) ? PORT_CPU :
                      (starve && dma_req) ? PORT_DMA :
                      cpu_req ? PORT_CPU : PORT_DMA;
    end
endmodule

// File: rtl/lvdc_mem_arbiter.sv
// lvdc_mem_arbiter: two-port memory arbiter and cs/oe/we access sequencer
module lvdc_mem_arbiter
    import lvdc_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_DEFER     = 3
) (
    input logic clk,
    input logic rst_n,
    lvdc_mem_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    port_e             port_q, port_d, grant_port;
    logic              grant_valid;
    logic [3:0]        cnt_q, cnt_d, defer_q, defer_d;
    logic              wr_q, wr_d, lock_q, lock_d, lgrant_q, lgrant_d;
    logic              cs_q, cs_d, oe_q, oe_d, we_q, we_d, busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

    lvdc_mem_arb_pick u_pick (
        .cpu_req     (bus.cpu_req),
        .dma_req     (bus.dma_req),
        .lock        (lock_q),
        .starve      (defer_q == 4'(MAX_DEFER)),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // next-state for the IDLE/ACCESS/DONE sequencer and all registered outputs
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        defer_d     = defer_q;
        wr_d        = wr_q;
        lock_d      = lock_q;
        lgrant_d    = lgrant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = cs_q;
        oe_d        = oe_q;
        we_d        = we_q;
        busy_d      = busy_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                lock_d = 1'b0;
                if (grant_valid) begin
                    state_d  = ACCESS;
                    port_d   = grant_port;
                    cnt_d    = 4'd1;
                    lgrant_d = lock_q && bus.cpu_req;
                    wr_d     = (grant_port == PORT_CPU) ? bus.cpu_we : bus.dma_we;
                    addr_d   = (grant_port == PORT_CPU) ? bus.cpu_addr : bus.dma_addr;
                    wdata_d  = (grant_port == PORT_CPU) ? bus.cpu_wdata : bus.dma_wdata;
                    defer_d  = (grant_port == PORT_DMA) ? 4'd0 :
                               (bus.dma_req && defer_q != 4'(MAX_DEFER)) ? defer_q + 4'd1 : defer_q;
                    cs_d     = 1'b1;
                    oe_d     = !wr_d;
                    we_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'(ACCESS_CYCLES)) begin
                    state_d     = DONE;
                    cs_d        = 1'b0;
                    oe_d        = 1'b0;
                    we_d        = 1'b0;
                    cpu_ack_d   = port_q == PORT_CPU;
                    dma_ack_d   = port_q == PORT_DMA;
                    cpu_rdata_d = (!wr_q && port_q == PORT_CPU) ? bus.mem_rdata : cpu_rdata_q;
                    dma_rdata_d = (!wr_q && port_q == PORT_DMA) ? bus.mem_rdata : dma_rdata_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    we_d  = wr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                lock_d  = port_q == PORT_CPU && bus.cpu_lock && !lgrant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; async reset drops the strobes at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= PORT_CPU;
            cnt_q       <= '0;
            defer_q     <= '0;
            wr_q        <= 1'b0;
            lock_q      <= 1'b0;
            lgrant_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            defer_q     <= defer_d;
            wr_q        <= wr_d;
            lock_q      <= lock_d;
            lgrant_q    <= lgrant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_cs    = cs_q;
    assign bus.mem_oe    = oe_q;
    assign bus.mem_we    = we_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_lvdc_mem_arbiter.sv
// tb_lvdc_mem_arbiter: directed self-checking bench for lvdc_mem_arbiter
module tb_lvdc_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    lvdc_mem_arbiter_if bus ();

    lvdc_mem_arbiter #(.ACCESS_CYCLES(2), .MAX_DEFER(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_lock = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_lock = 1'($urandom);
            bus.cpu_addr = 15'($urandom); bus.cpu_wdata = 26'($urandom);
            bus.dma_req = 1'($urandom); bus.dma_we = 1'($urandom);
            bus.dma_addr = 15'($urandom); bus.dma_wdata = 26'($urandom); bus.mem_rdata = 26'($urandom);
        end
        @(negedge clk);
        outs = {bus.mem_cs, bus.mem_oe, bus.mem_we, bus.busy, bus.cpu_ack, bus.dma_ack, 2'b00};
        n_checks++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000000", outs); end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_buses: got %h %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.dma_rdata);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.mem_cs} !== 2'b00) begin n_fail++; $display("FAIL reset_no_req_grant: busy/cs %b want 00", {bus.busy, bus.mem_cs}); end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h1234; bus.mem_rdata = 26'h2AAAAAA;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.mem_cs, bus.mem_oe, bus.mem_we, bus.busy, bus.cpu_ack} !== 5'b11010) begin
                n_fail++; $display("FAIL read_strobes_c%0d: cs/oe/we/busy/ack %b want 11010", c, {bus.mem_cs, bus.mem_oe, bus.mem_we, bus.busy, bus.cpu_ack});
            end
            n_checks++;
            if (bus.mem_addr !== 15'h1234) begin n_fail++; $display("FAIL read_addr: got %h want 1234", bus.mem_addr); end
        end
        @(negedge clk);
        bus.cpu_req = 0;
        n_checks++;
        if ({bus.cpu_ack, bus.dma_ack, bus.mem_cs, bus.mem_oe, bus.busy} !== 5'b10001) begin
            n_fail++; $display("FAIL read_done: ack/dack/cs/oe/busy %b want 10001", {bus.cpu_ack, bus.dma_ack, bus.mem_cs, bus.mem_oe, bus.busy});
        end
        n_checks++;
        if (bus.cpu_rdata !== 26'h2AAAAAA) begin n_fail++; $display("FAIL read_cpu_rdata: got %h want 2aaaaaa", bus.cpu_rdata); end
        n_checks++;
        if (bus.dma_rdata !== 26'h0) begin n_fail++; $display("FAIL read_dma_rdata: got %h want 0", bus.dma_rdata); end
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_ack, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL read_idle: ack/busy %b want 00", {bus.cpu_ack, bus.busy}); end
    endtask

    task automatic test_dma_write();
        logic [1:0] exp_we [2] = '{1'b0, 1'b1};
        int acks = 0;
        @(negedge clk);
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 15'h7FFF; bus.dma_wdata = 26'h3FFFFFF; bus.mem_rdata = 26'h0123456;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.mem_cs, bus.mem_oe, bus.mem_we} !== {2'b10, exp_we[c][0]}) begin
                n_fail++; $display("FAIL write_strobes_c%0d: cs/oe/we %b want 10%b", c + 1, {bus.mem_cs, bus.mem_oe, bus.mem_we}, exp_we[c][0]);
            end
            n_checks++;
            if ({bus.mem_addr, bus.mem_wdata} !== {15'h7FFF, 26'h3FFFFFF}) begin
                n_fail++; $display("FAIL write_bus: got %h %h want 7fff 3ffffff", bus.mem_addr, bus.mem_wdata);
            end
        end
        @(negedge clk);
        bus.dma_req = 0;
        acks += bus.dma_ack;
        n_checks++;
        if ({bus.mem_cs, bus.mem_we, bus.cpu_ack} !== 3'b000) begin n_fail++; $display("FAIL write_done_strobes: cs/we/cack %b want 000", {bus.mem_cs, bus.mem_we, bus.cpu_ack}); end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {15'h7FFF, 26'h3FFFFFF}) begin n_fail++; $display("FAIL write_done_bus: got %h %h want 7fff 3ffffff", bus.mem_addr, bus.mem_wdata); end
        repeat (3) begin @(negedge clk); acks += bus.dma_ack; end
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL write_ack_count: got %0d want 1", acks); end
        n_checks++;
        if ({bus.dma_rdata, bus.cpu_rdata} !== {26'h0, 26'h2AAAAAA}) begin
            n_fail++; $display("FAIL write_rdata_kept: dma %h cpu %h want 0 2aaaaaa", bus.dma_rdata, bus.cpu_rdata);
        end
    endtask

    task automatic run_contest(input string name, input int want, input logic exp [8], input bit use_lock);
        logic seq [8];
        int   n = 0;
        int   cpu_n = 0;
        logic prev = 0;
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.dma_req = 1; bus.dma_we = 0;
        for (int c = 0; c < 60 && n < want; c++) begin
            @(negedge clk);
            n_checks++;
            if ((bus.cpu_ack && bus.dma_ack) || (prev && (bus.cpu_ack || bus.dma_ack))) begin
                n_fail++; $display("FAIL %s_ack_pulse: cack %b dack %b prev %b want single-cycle exclusive", name, bus.cpu_ack, bus.dma_ack, prev);
            end
            prev = bus.cpu_ack | bus.dma_ack;
            if (prev) begin
                seq[n] = bus.dma_ack;
                n++;
                if (bus.cpu_ack) cpu_n++;
                if (use_lock && cpu_n == 3) bus.cpu_lock = 1;
            end
        end
        bus.cpu_req = 0; bus.dma_req = 0;
        n_checks++;
        if (n != want) begin n_fail++; $display("FAIL %s_timeout: got %0d acks want %0d", name, n, want); end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (seq[i] !== exp[i]) begin n_fail++; $display("FAIL %s_grant%0d: got %s want %s", name, i, seq[i] ? "D" : "C", exp[i] ? "D" : "C"); end
        end
        @(negedge clk);
        bus.cpu_lock = 0;
    endtask

    task automatic test_contention();
        logic exp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        run_contest("contend", 8, exp, 1'b0);
    endtask

    task automatic test_lock();
        logic exp [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        run_contest("lock", 5, exp, 1'b1);
    endtask

    task automatic test_reset_mid();
        int wait_n = 0;
        int stray = 0;
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'h0042; bus.mem_rdata = 26'h1555555;
        @(negedge clk);
        n_checks++;
        if (bus.mem_cs !== 1'b1) begin n_fail++; $display("FAIL mid_cs_before: got %b want 1", bus.mem_cs); end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({bus.mem_cs, bus.mem_oe, bus.busy, bus.cpu_ack} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_async_drop: cs/oe/busy/ack %b want 0000", {bus.mem_cs, bus.mem_oe, bus.busy, bus.cpu_ack});
        end
        bus.cpu_req = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (6) begin @(negedge clk); stray += bus.cpu_ack; end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks want 0", stray); end
        bus.cpu_req = 1;
        for (int c = 1; c <= 10 && wait_n == 0; c++) begin
            @(negedge clk);
            if (bus.cpu_ack) wait_n = c;
        end
        bus.cpu_req = 0;
        n_checks++;
        if (wait_n != 3) begin n_fail++; $display("FAIL mid_fresh_latency: got %0d want 3", wait_n); end
        n_checks++;
        if (bus.cpu_rdata !== 26'h1555555) begin n_fail++; $display("FAIL mid_fresh_rdata: got %h want 1555555", bus.cpu_rdata); end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_contention();
        test_lock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
